dmem_arbiter: RTL and testbench

- Shares the single-port 64x16 data memory between two requesters: port 0 (core load/store) and port 1 (debug/loader DMA).
- Sits between the requesters and the memory's clk0/csb0/web0/addr0/din0/dout0 interface.
- Issues at most one access per cycle.
- Supports locked bursts and routes the registered read data (1-cycle latency) back to the issuing port.

---
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM, with locked bursts and 1-cycle read return.
// Define DMEM_ARB_RR_EN for round-robin IDLE arbitration; otherwise port 0 always wins contention.
module dmem_arbiter #(
  parameter int AW        = 6,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic          p0_lock,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic          p1_lock,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_csb,
  output logic          mem_web,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int            CW       = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_port_q, rd_port_d;

  logic          own_hold;
  logic          gnt0, gnt1, issue, sel;
  logic          sel_we, sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [CW-1:0] run_cnt;

  // Arbitration; grants are suppressed while reset is asserted.
  always_comb begin
    own_hold = ((state_q == OWN0) && p0_req) || ((state_q == OWN1) && p1_req);
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    if (!reset) begin
      if ((state_q == OWN0) && p0_req) begin
        gnt0 = 1'b1;
      end else if ((state_q == OWN1) && p1_req) begin
        gnt1 = 1'b1;
      end else if (p0_req && p1_req) begin
        gnt0 = ~rr_ptr_q;
        gnt1 = rr_ptr_q;
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
    issue     = gnt0 | gnt1;
    sel       = gnt1;
    sel_we    = sel ? p1_we    : p0_we;
    sel_lock  = sel ? p1_lock  : p0_lock;
    sel_addr  = sel ? p1_addr  : p0_addr;
    sel_wdata = sel ? p1_wdata : p0_wdata;
    // A grant that does not continue the current ownership starts a fresh burst count.
    run_cnt   = own_hold ? burst_cnt_q : '0;
  end

  always_comb begin
    state_d     = IDLE;
    burst_cnt_d = '0;
    rr_ptr_d    = rr_ptr_q;
    rd_pend_d   = issue && !sel_we;
    rd_port_d   = sel;
    if (issue) begin
      if (sel_lock && (run_cnt < LAST_CNT)) begin
        state_d     = sel ? OWN1 : OWN0;
        burst_cnt_d = run_cnt + CW'(1);
      end else begin
`ifdef DMEM_ARB_RR_EN
        rr_ptr_d = ~sel;
`else
        rr_ptr_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_port_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_port_q   <= rd_port_d;
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign mem_csb   = ~issue;
  assign mem_web   = issue ? ~sel_we : 1'b1;
  assign mem_addr  = issue ? sel_addr  : '0;
  assign mem_din   = issue ? sel_wdata : '0;

  // Read data is steered to the issuing port only; the other port sees zero.
  assign p0_rvalid = rd_pend_q & ~rd_port_q;
  assign p1_rvalid = rd_pend_q &  rd_port_q;
  assign p0_rdata  = p0_rvalid ? mem_dout : '0;
  assign p1_rdata  = p1_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model predicts grants and read returns per cycle,
// and a separate monitor compares DUT bus/grant/return outputs against the queued expectations.
module tb_dmem_arbiter;
  localparam int AW        = 6;
  localparam int DW        = 16;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_csb, mem_web;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Single-port RAM with registered read, as the arbiter sees it.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!mem_csb) begin
      if (!mem_web) ram[mem_addr] <= mem_din;
      else          mem_dout      <= ram[mem_addr];
    end
  end

  typedef struct {
    int            cyc;
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } iss_t;
  typedef struct {
    int            cyc;
    logic          port;
    logic [DW-1:0] data;
  } rd_t;

  iss_t iss_q[$];
  rd_t  rd_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model state: who owns the memory, how many accesses in this ownership,
  // which port is preferred on contention, and what read is in flight.
  int            m_owner = -1;
  int            m_run = 0;
  logic          m_pref = 1'b0;
  logic          m_pend = 1'b0;
  logic          m_pend_port = 1'b0;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic l0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            winner;
    int            run;
    logic          lk;
    iss_t          e;
    rd_t           r;
    @(negedge clk);
    cyc++;
    reset = rst;
    p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
    #1;
    if (rst) begin
      m_pend = 1'b0; m_owner = -1; m_run = 0; m_pref = 1'b0;
      return;
    end
    if (m_pend) begin
      r.cyc = cyc; r.port = m_pend_port; r.data = m_pend_data;
      rd_q.push_back(r);
      m_pend = 1'b0;
    end
    winner = -1;
    if (m_owner == 0 && r0)      winner = 0;
    else if (m_owner == 1 && r1) winner = 1;
    else if (r0 && r1)           winner = m_pref ? 1 : 0;
    else if (r0)                 winner = 0;
    else if (r1)                 winner = 1;
    if (winner >= 0) begin
      e.cyc  = cyc;
      e.port = (winner == 1);
      e.we   = e.port ? w1 : w0;
      e.addr = e.port ? a1 : a0;
      e.data = e.port ? d1 : d0;
      lk     = e.port ? l1 : l0;
      iss_q.push_back(e);
      if (e.we) shadow[e.addr] = e.data;
      else begin
        m_pend = 1'b1; m_pend_port = e.port; m_pend_data = shadow[e.addr];
      end
      run = (winner == m_owner) ? m_run + 1 : 1;
      if (lk && run < MAX_BURST) begin
        m_owner = winner; m_run = run;
      end else begin
        m_owner = -1; m_run = 0;
`ifdef DMEM_ARB_RR_EN
        m_pref = (winner == 0);
`else
        m_pref = 1'b0;
`endif
      end
    end else begin
      m_owner = -1; m_run = 0;
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: mid-cycle, compare the bus/grant outputs and the read-return outputs.
  logic [2*1+2+AW+DW-1:0] exp_i, act_i;
  logic [2+2*DW-1:0]      exp_r, act_r;
  initial begin
    iss_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      #3;
      exp_i = {1'b0, 1'b0, 1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}};
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
        e = iss_q.pop_front();
        exp_i = {~e.port, e.port, 1'b0, ~e.we, e.addr, e.data};
      end
      act_i = {p0_gnt, p1_gnt, mem_csb, mem_web, mem_addr, mem_din};
      n_checks++;
      if (act_i === exp_i) n_pass++;
      else $display("FAIL issue cyc=%0d got gnt/csb/web/addr/din=%h want %h", cyc, act_i, exp_i);

      exp_r = '0;
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        r = rd_q.pop_front();
        exp_r = {~r.port, r.port, r.port ? {DW{1'b0}} : r.data, r.port ? r.data : {DW{1'b0}}};
      end
      act_r = {p0_rvalid, p1_rvalid, p0_rdata, p1_rdata};
      n_checks++;
      if (act_r === exp_r) n_pass++;
      else $display("FAIL rdret cyc=%0d got rvalid01/rdata0/rdata1=%h want %h", cyc, act_r, exp_r);
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'(16'hA000 ^ (i * 16'h0111));
      shadow[i] = DW'(16'hA000 ^ (i * 16'h0111));
    end

    idle(1'b1);
    idle(1'b1);
    // Write then read back on port 0.
    step(1'b0, 1'b1, 1'b1, 1'b0, 6'h05, 16'hBEEF, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'h05, 16'h0000, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b0);
    // Continuous contention without lock.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, AW'(i), 16'h1111, 1'b1, 1'b0, 1'b0, AW'(32 + i), 16'h2222);
    idle(1'b0);
    // Port 1 locked burst, port 0 joins and waits for the forced release.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 6'h10, '0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 6'h20, '0, 1'b1, 1'b0, 1'b1, AW'(17 + i), '0);
    idle(1'b0);
    // Owner drops its request: the other port wins in the same cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 6'h11, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'h11, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b0);
    // Reset lands on the cycle a read return is due.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 6'h3F, '0);
    idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'h02, '0, 1'b1, 1'b0, 1'b0, 6'h03, '0);
    idle(1'b0);
    // Back-to-back reads on alternating ports.
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 6'h3F, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'h01, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b0);
    idle(1'b0);
    // Randomised traffic with occasional reset.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0),
           AW'($urandom_range(0, 63)), DW'($urandom),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0),
           AW'($urandom_range(0, 63)), DW'($urandom));
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    @(negedge clk);
    #5;
    n_checks++;
    if (iss_q.size() == 0 && rd_q.size() == 0) n_pass++;
    else $display("FAIL leftover got issues=%0d reads=%0d want 0/0", iss_q.size(), rd_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
